// File: rtl/cirno9_sram_ctrl_pkg.sv
// Shared types and helpers for the cirno9 LSU-to-SRAM-macro controller.
// Holds the access FSM encoding and the address-window test.
package cirno9_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sram_state_t;

  localparam int DATA_W = 32;
  localparam int WEN_W  = 4;

  // off is the word offset from the window base; addresses below the base
  // wrap to large values, so a single upper-bits test covers both sides.
  function automatic logic in_window(input logic [29:0] off, input int aw);
    return (off >> aw) == 30'd0;
  endfunction

endpackage

// File: rtl/cirno9_sram_ctrl.sv
// Converts the core's hold-until-ready SRAM request into one timed access on a
// synchronous single-port macro with RD_LAT read latency, flagging out-of-window addresses.
module cirno9_sram_ctrl
  import cirno9_sram_ctrl_pkg::*;
#(
  parameter int          AW     = 14,
  parameter logic [31:0] BASE   = 32'h0000_0000,
  parameter int          RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ren,
  input  logic [WEN_W-1:0]  i_wen,
  input  logic [31:0]       i_adr,
  input  logic [DATA_W-1:0] i_wdat,
  output logic              o_rdy,
  output logic [DATA_W-1:0] o_rdat,
  output logic              o_err,
  output logic              o_mem_cs,
  output logic [WEN_W-1:0]  o_mem_we,
  output logic [AW-1:0]     o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdat,
  input  logic [DATA_W-1:0] i_mem_rdat
);

  localparam int CW = $clog2(RD_LAT) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);
  localparam logic [29:0]   BASE_W   = BASE[31:2];

  generate
    if (RD_LAT < 1) begin : g_rd_lat_chk
      $error("cirno9_sram_ctrl: RD_LAT must be >= 1");
    end
  endgenerate

  sram_state_t state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic              rd_p0;
  logic [WEN_W-1:0]  wen_p0;
  logic [AW-1:0]     addr_p0;
  logic [DATA_W-1:0] wdat_p0;
  logic [DATA_W-1:0] rdat_q;
  logic              err_q;

  logic        req;
  logic        hit;
  logic [29:0] off;
  logic        unused_adr_lsb;

  assign off            = i_adr[31:2] - BASE_W;
  assign hit            = in_window(off, AW);
  assign req            = i_ren | (|i_wen);
  assign unused_adr_lsb = ^i_adr[1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req) state_d = hit ? ST_ISSUE : ST_RESP;
      ST_ISSUE: state_d = rd_p0 ? ST_WAIT : ST_RESP;
      ST_WAIT:  if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_mem_cs = 1'b0;
    o_mem_we = '0;
    o_rdy    = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        o_mem_cs = 1'b1;
        o_mem_we = wen_p0;
      end
      ST_RESP:  o_rdy = 1'b1;
      default: ;
    endcase
  end

  // Request capture (IDLE edge) / macro wait / read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      rd_p0   <= 1'b0;
      wen_p0  <= '0;
      addr_p0 <= '0;
      wdat_p0 <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            rd_p0  <= ~(|i_wen);
            wen_p0 <= i_wen;
            if (hit) begin
              addr_p0 <= off[AW-1:0];
              wdat_p0 <= i_wdat;
            end else if (~(|i_wen)) begin
              rdat_q <= '0;
            end
          end
        end
        ST_ISSUE: cnt_q <= CNT_INIT;
        ST_WAIT: begin
          if (cnt_q == '0) rdat_q <= i_mem_rdat;
          else             cnt_q  <= cnt_q - CW'(1);
        end
        default: ;
      endcase
      // err only changes on entry to RESP so it stays aligned with o_rdy
      if (state_d == ST_RESP && state_q != ST_RESP)
        err_q <= (state_q == ST_IDLE);
    end
  end

  assign o_rdat     = rdat_q;
  assign o_err      = err_q;
  assign o_mem_addr = addr_p0;
  assign o_mem_wdat = wdat_p0;

endmodule

// File: tb/tb_cirno9_sram_ctrl.sv
// Directed bench for cirno9_sram_ctrl: one RD_LAT=1 and one RD_LAT=3 instance,
// each with a behavioural macro model.
module tb_cirno9_sram_ctrl;

  localparam int          AW   = 6;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ren1 = 0, ren3 = 0;
  logic [3:0]  wen1 = 0, wen3 = 0;
  logic [31:0] adr1 = 0, adr3 = 0, wdat1 = 0, wdat3 = 0;
  logic        rdy1, rdy3, err1, err3, cs1, cs3;
  logic [3:0]  we1, we3;
  logic [31:0] rdat1, rdat3, mwdat1, mwdat3, mrdat1, mrdat3;
  logic [AW-1:0] maddr1, maddr3;

  cirno9_sram_ctrl #(.AW(AW), .BASE(BASE), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .i_ren(ren1), .i_wen(wen1), .i_adr(adr1), .i_wdat(wdat1),
    .o_rdy(rdy1), .o_rdat(rdat1), .o_err(err1), .o_mem_cs(cs1), .o_mem_we(we1),
    .o_mem_addr(maddr1), .o_mem_wdat(mwdat1), .i_mem_rdat(mrdat1));

  cirno9_sram_ctrl #(.AW(AW), .BASE(BASE), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .i_ren(ren3), .i_wen(wen3), .i_adr(adr3), .i_wdat(wdat3),
    .o_rdy(rdy3), .o_rdat(rdat3), .o_err(err3), .o_mem_cs(cs3), .o_mem_we(we3),
    .o_mem_addr(maddr3), .o_mem_wdat(mwdat3), .i_mem_rdat(mrdat3));

  // Macro models
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [31:0] p0 = 0, p1 = 0, p2 = 0;
  logic [31:0] rd1 = 0;
  initial for (int i = 0; i < 64; i++) begin mem1[i] = 0; mem3[i] = 0; end

  always @(posedge clk) begin
    if (cs1) begin
      for (int b = 0; b < 4; b++) if (we1[b]) mem1[maddr1][8*b +: 8] <= mwdat1[8*b +: 8];
      rd1 <= mem1[maddr1];
    end
  end
  assign mrdat1 = rd1;

  always @(posedge clk) begin
    if (cs3) begin
      for (int b = 0; b < 4; b++) if (we3[b]) mem3[maddr3][8*b +: 8] <= mwdat3[8*b +: 8];
      p0 <= mem3[maddr3];
    end
    p1 <= p0;
    p2 <= p1;
  end
  assign mrdat3 = p2;

  // Instance selected by the access task
  logic        sel = 0;
  logic        o_rdy_s, o_cs_s, o_err_s;
  logic [3:0]  o_we_s;
  logic [31:0] o_rdat_s;
  logic [AW-1:0] o_addr_s;
  assign o_rdy_s  = sel ? rdy3   : rdy1;
  assign o_cs_s   = sel ? cs3    : cs1;
  assign o_err_s  = sel ? err3   : err1;
  assign o_we_s   = sel ? we3    : we1;
  assign o_rdat_s = sel ? rdat3  : rdat1;
  assign o_addr_s = sel ? maddr3 : maddr1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin ren3 = r; wen3 = w; adr3 = a; wdat3 = d; end
    else     begin ren1 = r; wen1 = w; adr1 = a; wdat1 = d; end
  endtask

  int          lat, cs_n;
  logic [3:0]  we_seen;
  logic [AW-1:0] addr_seen;

  // Called at a negedge; returns at a negedge one idle cycle after o_rdy.
  task automatic access(input string tag, input logic r, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d, input bit drop);
    lat = 0; cs_n = 0; we_seen = 4'hx; addr_seen = 'x;
    drive(r, w, a, d);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1 && drop) drive(1'b0, 4'h0, a + 32'd4, ~d);
      if (o_cs_s) begin cs_n++; we_seen = o_we_s; addr_seen = o_addr_s; end
      if (o_rdy_s) begin lat = n; break; end
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk({tag, "_rdy_pulse"}, {31'd0, o_rdy_s}, 32'd0);
    @(negedge clk);
  endtask

  int first_rdy, second_rdy, rdy_cnt;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",   {31'd0, rdy1}, 0);
    chk("rst_rdat",  rdat1, 0);
    chk("rst_err",   {31'd0, err1}, 0);
    chk("rst_cs",    {31'd0, cs1}, 0);
    chk("rst_we",    {28'd0, we1}, 0);
    chk("rst_addr",  {26'd0, maddr1}, 0);
    chk("rst_wdat",  mwdat1, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);

    sel = 0;
    access("wr1", 1'b0, 4'hF, BASE + 32'h10, 32'hDEADBEEF, 0);
    chk("wr1_lat", lat, 2);
    chk("wr1_cs_n", cs_n, 1);
    chk("wr1_we", {28'd0, we_seen}, 32'hF);
    chk("wr1_addr", {26'd0, addr_seen}, 4);
    chk("wr1_err", {31'd0, err1}, 0);

    access("rd1", 1'b1, 4'h0, BASE + 32'h10, 32'h0, 0);
    chk("rd1_lat", lat, 3);
    chk("rd1_cs_n", cs_n, 1);
    chk("rd1_we", {28'd0, we_seen}, 0);
    chk("rd1_rdat", rdat1, 32'hDEADBEEF);
    chk("rd1_err", {31'd0, err1}, 0);

    access("bw", 1'b0, 4'b0010, BASE + 32'h10, 32'h0000AB00, 0);
    chk("bw_lat", lat, 2);
    access("bw_rd", 1'b1, 4'h0, BASE + 32'h12, 32'h0, 0);
    chk("bw_rdat", rdat1, 32'hDEADABEF);

    access("oow", 1'b1, 4'h0, BASE + 32'h100, 32'h0, 0);
    chk("oow_lat", lat, 1);
    chk("oow_cs_n", cs_n, 0);
    chk("oow_err", {31'd0, err1}, 1);
    chk("oow_rdat", rdat1, 0);
    chk("oow_addr_hold", {26'd0, maddr1}, 4);

    access("good", 1'b1, 4'h0, BASE + 32'h10, 32'h0, 0);
    chk("good_err", {31'd0, err1}, 0);
    chk("good_rdat", rdat1, 32'hDEADABEF);

    access("both", 1'b1, 4'hF, BASE + 32'h14, 32'h12345678, 0);
    chk("both_lat", lat, 2);
    chk("both_we", {28'd0, we_seen}, 32'hF);
    chk("both_rdat_keep", rdat1, 32'hDEADABEF);
    access("both_rd", 1'b1, 4'h0, BASE + 32'h14, 32'h0, 0);
    chk("both_mem", rdat1, 32'h12345678);

    access("oow_lo", 1'b0, 4'hF, BASE - 32'h4, 32'h55555555, 0);
    chk("oow_lo_lat", lat, 1);
    chk("oow_lo_err", {31'd0, err1}, 1);
    chk("oow_lo_rdat_keep", rdat1, 32'h12345678);

    access("drop", 1'b1, 4'h0, BASE + 32'h10, 32'h0, 1);
    chk("drop_lat", lat, 3);
    chk("drop_rdat", rdat1, 32'hDEADABEF);
    chk("drop_err", {31'd0, err1}, 0);

    // Request held across completion: second access one idle cycle later
    first_rdy = 0; second_rdy = 0; rdy_cnt = 0;
    drive(1'b1, 4'h0, BASE + 32'h14, 32'h0);
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (rdy1) begin
        rdy_cnt++;
        if (rdy_cnt == 1) first_rdy = n; else second_rdy = n;
      end
      if (n == 7) drive(1'b0, 4'h0, 32'h0, 32'h0);
    end
    chk("b2b_cnt", rdy_cnt, 2);
    chk("b2b_first", first_rdy, 3);
    chk("b2b_second", second_rdy, 7);
    chk("b2b_rdat", rdat1, 32'h12345678);
    repeat (2) @(negedge clk);

    // Reset while waiting on the macro
    drive(1'b1, 4'h0, BASE + 32'h10, 32'h0);
    @(posedge clk); #1;
    chk("rw_issue_cs", {31'd0, cs1}, 1);
    @(posedge clk); #1;
    chk("rw_wait_rdy", {31'd0, rdy1}, 0);
    @(negedge clk);
    rst = 1;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("rw_rdy", {31'd0, rdy1}, 0);
    chk("rw_rdat", rdat1, 0);
    chk("rw_addr", {26'd0, maddr1}, 0);
    chk("rw_wdat", mwdat1, 0);
    chk("rw_cs", {31'd0, cs1}, 0);
    @(negedge clk); rst = 0;
    rdy_cnt = 0;
    repeat (4) begin @(posedge clk); #1; if (rdy1) rdy_cnt++; end
    chk("rw_no_rdy", rdy_cnt, 0);
    @(negedge clk);
    access("rw_fresh", 1'b1, 4'h0, BASE + 32'h10, 32'h0, 0);
    chk("rw_fresh_lat", lat, 3);
    chk("rw_fresh_rdat", rdat1, 32'hDEADABEF);

    // RD_LAT=3 instance
    sel = 1;
    access("l3_wr", 1'b0, 4'hF, BASE + 32'h20, 32'hCAFEF00D, 0);
    chk("l3_wr_lat", lat, 2);
    access("l3_rd", 1'b1, 4'h0, BASE + 32'h20, 32'h0, 0);
    chk("l3_rd_lat", lat, 5);
    chk("l3_rd_cs_n", cs_n, 1);
    chk("l3_rd_addr", {26'd0, addr_seen}, 8);
    chk("l3_rd_rdat", rdat3, 32'hCAFEF00D);
    chk("l3_rd_err", {31'd0, o_err_s}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
